// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch PC generator with a direct-mapped branch target buffer
module pc_gen_btb #(
  parameter int XLEN = 64,
  parameter int BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            switch_mode,
  input  logic [XLEN-1:0] pc_csr,
  input  logic            stall,
  input  logic            exe_valid,
  input  logic            exe_is_cf,
  input  logic            exe_taken,
  input  logic [XLEN-1:0] exe_pc,
  input  logic [XLEN-1:0] exe_target,
  input  logic            exe_pred_taken,
  input  logic [XLEN-1:0] exe_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] next_pc,
  output logic            flush
);
  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;
  logic [BTB_DEPTH-1:0] valid;
  logic [TW-1:0]        tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];
  logic [IW-1:0]        ridx, widx;
  logic                 rhit, whit, mispredict, upd, wr_en, wr_valid;
  logic [XLEN-1:0]      pc_inc, redirect, wr_target;
  logic [1:0]           wr_ctr, cur_ctr;
  assign ridx        = pc[IW+1:2];
  assign rhit        = valid[ridx] && tag_q[ridx] == pc[XLEN-1:IW+2];
  assign pc_inc      = pc + XLEN'(4);
  assign pred_taken  = rhit && ctr_q[ridx][1];
  assign pred_target = rhit ? target_q[ridx] : pc_inc;
  assign widx        = exe_pc[IW+1:2];
  assign whit        = valid[widx] && tag_q[widx] == exe_pc[XLEN-1:IW+2];
  assign cur_ctr     = ctr_q[widx];
  assign mispredict  = exe_valid && (exe_is_cf
                         ? (exe_taken != exe_pred_taken || (exe_taken && exe_target != exe_pred_target))
                         : exe_pred_taken);
  assign redirect    = (exe_is_cf && exe_taken) ? exe_target : exe_pc + XLEN'(4);
  assign flush       = switch_mode || (!stall && mispredict);
  assign upd         = exe_valid && !stall && !switch_mode;
  // fetch PC selection, trap/xret first, then stall, redirect, prediction
  always_comb
    next_pc = switch_mode ? pc_csr : stall ? pc : mispredict ? redirect : pred_taken ? pred_target : pc_inc;
  // single-entry BTB write: train on a hit, allocate on a taken miss, drop aliased non-cf entries
  always_comb begin
    wr_en     = upd && (exe_is_cf ? (whit || exe_taken) : whit);
    wr_valid  = exe_is_cf;
    wr_target = (exe_is_cf && exe_taken) ? exe_target : target_q[widx];
    wr_ctr    = !exe_is_cf ? cur_ctr
              : !whit ? 2'b10
              : exe_taken ? (cur_ctr == 2'b11 ? cur_ctr : cur_ctr + 2'd1)
              : (cur_ctr == 2'b00 ? cur_ctr : cur_ctr - 2'd1);
  end
  // PC register and resettable BTB state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= 2'b01;
    end else begin
      pc <= next_pc;
      if (wr_en) begin
        valid[widx] <= wr_valid;
        ctr_q[widx] <= wr_ctr;
      end
    end
  end
  // tag and target storage carries no reset; valid gates every use
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[widx]    <= exe_pc[XLEN-1:IW+2];
      target_q[widx] <= wr_target;
    end
  end
endmodule

// File: tb/tb_pc_gen_btb.sv
// tb_pc_gen_btb: directed checks of fetch sequencing, BTB training, priority and reset
module tb_pc_gen_btb;
  logic        clk = 0, rst = 0, switch_mode = 0, stall = 0;
  logic        exe_valid = 0, exe_is_cf = 0, exe_taken = 0, exe_pred_taken = 0;
  logic [63:0] pc_csr = 0, exe_pc = 0, exe_target = 0, exe_pred_target = 0;
  logic [63:0] pc, pred_target, next_pc;
  logic        pred_taken, flush;
  int checks = 0, failures = 0;

  pc_gen_btb #(.XLEN(64), .BTB_DEPTH(16), .RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst), .switch_mode(switch_mode), .pc_csr(pc_csr), .stall(stall),
    .exe_valid(exe_valid), .exe_is_cf(exe_is_cf), .exe_taken(exe_taken), .exe_pc(exe_pc),
    .exe_target(exe_target), .exe_pred_taken(exe_pred_taken), .exe_pred_target(exe_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target), .next_pc(next_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exe();
    exe_valid = 0; exe_is_cf = 0; exe_taken = 0; exe_pred_taken = 0;
    exe_pc = 0; exe_target = 0; exe_pred_target = 0;
    switch_mode = 0; stall = 0; pc_csr = 0;
  endtask

  task automatic set_exe(input logic cf, input logic tk, input logic [63:0] epc,
                         input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
    exe_valid = 1; exe_is_cf = cf; exe_taken = tk; exe_pc = epc;
    exe_target = tgt; exe_pred_taken = ptk; exe_pred_target = ptgt;
  endtask

  task automatic goto_pc(input logic [63:0] a);
    clear_exe();
    switch_mode = 1; pc_csr = a;
    tick();
    switch_mode = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_exe();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (pc !== 64'h1000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 64'h1000); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 64'h1004) begin failures++; $display("FAIL reset_pred_target got=%h exp=%h", pred_target, 64'h1004); end
  endtask

  task automatic test_sequential();
    checks++; if (next_pc !== 64'h1004) begin failures++; $display("FAIL seq_next got=%h exp=%h", next_pc, 64'h1004); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL seq_flush got=%b exp=0", flush); end
    tick();
    checks++; if (pc !== 64'h1004) begin failures++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 64'h1004); end
    tick();
    checks++; if (pc !== 64'h1008) begin failures++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 64'h1008); end
  endtask

  task automatic test_alloc();
    set_exe(1, 1, 64'h1008, 64'h2000, 0, 64'h0);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL alloc_flush got=%b exp=1", flush); end
    checks++; if (next_pc !== 64'h2000) begin failures++; $display("FAIL alloc_next got=%h exp=%h", next_pc, 64'h2000); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alloc_same_cycle_pred got=%b exp=0", pred_taken); end
    tick();
    checks++; if (pc !== 64'h2000) begin failures++; $display("FAIL alloc_pc got=%h exp=%h", pc, 64'h2000); end
    clear_exe();
    switch_mode = 1; pc_csr = 64'h1008;
    #1;
    checks++; if (next_pc !== 64'h1008 || flush !== 1'b1) begin failures++; $display("FAIL switch_next got=%h/%b exp=%h/1", next_pc, flush, 64'h1008); end
    tick();
    switch_mode = 0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_hit_pred got=%b exp=1", pred_taken); end
    checks++; if (pred_target !== 64'h2000) begin failures++; $display("FAIL alloc_hit_target got=%h exp=%h", pred_target, 64'h2000); end
    checks++; if (next_pc !== 64'h2000 || flush !== 1'b0) begin failures++; $display("FAIL alloc_hit_next got=%h/%b exp=%h/0", next_pc, flush, 64'h2000); end
  endtask

  task automatic test_hysteresis();
    set_exe(1, 0, 64'h1008, 64'h0, 1, 64'h2000);
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL hyst_pre_update_pred got=%b exp=1", pred_taken); end
    checks++; if (next_pc !== 64'h100C || flush !== 1'b1) begin failures++; $display("FAIL hyst_nt_redirect got=%h/%b exp=%h/1", next_pc, flush, 64'h100C); end
    tick();
    goto_pc(64'h1008);
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL hyst_ctr1_pred got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 64'h2000) begin failures++; $display("FAIL hyst_ctr1_target got=%h exp=%h", pred_target, 64'h2000); end
    checks++; if (next_pc !== 64'h100C) begin failures++; $display("FAIL hyst_ctr1_next got=%h exp=%h", next_pc, 64'h100C); end
    set_exe(1, 1, 64'h1008, 64'h2000, 1, 64'h2000);
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL hyst_correct_flush got=%b exp=0", flush); end
    tick(); tick(); tick();
    set_exe(1, 0, 64'h1008, 64'h0, 1, 64'h2000);
    tick();
    goto_pc(64'h1008);
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL hyst_saturate_pred got=%b exp=1", pred_taken); end
  endtask

  task automatic test_priority();
    switch_mode = 1; pc_csr = 64'h8000; stall = 1;
    set_exe(1, 1, 64'h1008, 64'h3000, 0, 64'h0);
    #1;
    checks++; if (next_pc !== 64'h8000 || flush !== 1'b1) begin failures++; $display("FAIL prio_switch got=%h/%b exp=%h/1", next_pc, flush, 64'h8000); end
    tick();
    checks++; if (pc !== 64'h8000) begin failures++; $display("FAIL prio_switch_pc got=%h exp=%h", pc, 64'h8000); end
    switch_mode = 0;
    #1;
    checks++; if (next_pc !== 64'h8000 || flush !== 1'b0) begin failures++; $display("FAIL prio_stall got=%h/%b exp=%h/0", next_pc, flush, 64'h8000); end
    tick();
    checks++; if (pc !== 64'h8000) begin failures++; $display("FAIL prio_stall_pc got=%h exp=%h", pc, 64'h8000); end
    goto_pc(64'h1008);
    checks++; if (pred_target !== 64'h2000 || pred_taken !== 1'b1) begin failures++; $display("FAIL prio_no_write got=%h/%b exp=%h/1", pred_target, pred_taken, 64'h2000); end
  endtask

  task automatic test_alias_conflict();
    set_exe(0, 0, 64'h1008, 64'h0, 1, 64'h2000);
    #1;
    checks++; if (next_pc !== 64'h100C || flush !== 1'b1) begin failures++; $display("FAIL alias_next got=%h/%b exp=%h/1", next_pc, flush, 64'h100C); end
    tick();
    goto_pc(64'h1008);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h100C) begin failures++; $display("FAIL alias_invalid got=%b/%h exp=0/%h", pred_taken, pred_target, 64'h100C); end
    set_exe(1, 1, 64'h1008, 64'h2000, 0, 64'h0);
    tick();
    set_exe(1, 1, 64'h1048, 64'h4000, 0, 64'h0);
    tick();
    goto_pc(64'h1008);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h100C) begin failures++; $display("FAIL conflict_evicted got=%b/%h exp=0/%h", pred_taken, pred_target, 64'h100C); end
    goto_pc(64'h1048);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h4000) begin failures++; $display("FAIL conflict_new got=%b/%h exp=1/%h", pred_taken, pred_target, 64'h4000); end
  endtask

  task automatic test_wrap();
    goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
    checks++; if (next_pc !== 64'h0) begin failures++; $display("FAIL wrap_next got=%h exp=0", next_pc); end
    tick();
    checks++; if (pc !== 64'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid();
    goto_pc(64'h1048);
    rst = 1; switch_mode = 1; pc_csr = 64'h8000;
    set_exe(1, 1, 64'h1048, 64'h5000, 0, 64'h0);
    tick();
    rst = 0;
    clear_exe();
    #1;
    checks++; if (pc !== 64'h1000) begin failures++; $display("FAIL rst_mid_pc got=%h exp=%h", pc, 64'h1000); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h1004) begin failures++; $display("FAIL rst_mid_pred got=%b/%h exp=0/%h", pred_taken, pred_target, 64'h1004); end
    goto_pc(64'h1048);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h104C) begin failures++; $display("FAIL rst_mid_miss got=%b/%h exp=0/%h", pred_taken, pred_target, 64'h104C); end
  endtask

  initial begin
    tick();
    test_reset();
    test_sequential();
    test_alloc();
    test_hysteresis();
    test_priority();
    test_alias_conflict();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_gen_btb.md
PC_GEN_BTB -- requirements
Module: pc_gen_btb

Interface
REQ-001 Parameter XLEN, default 64: address width.
REQ-002 Parameter BTB_DEPTH, default 16: BTB entries; power of 2, at least 2. IW = log2(BTB_DEPTH).
REQ-003 Parameter RESET_PC, default 64'h0: PC loaded on reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 switch_mode  in  1  trap/xret redirect request.
REQ-007 pc_csr  in  XLEN  trap/xret target.
REQ-008 stall  in  1  hold fetch PC and freeze BTB updates.
REQ-009 exe_valid  in  1  EXE stage holds a live instruction.
REQ-010 exe_is_cf  in  1  EXE instruction is a branch or jump.
REQ-011 exe_taken  in  1  resolved direction; jumps = 1.
REQ-012 exe_pc  in  XLEN  PC of the EXE instruction.
REQ-013 exe_target  in  XLEN  resolved target.
REQ-014 exe_pred_taken  in  1  prediction carried down the pipe with the EXE instruction.
REQ-015 exe_pred_target  in  XLEN  predicted target carried with the EXE instruction.
REQ-016 pc  out  XLEN  registered fetch PC.
REQ-017 pred_taken  out  1  BTB prediction for pc; combinational.
REQ-018 pred_target  out  XLEN  BTB target for pc; combinational.
REQ-019 next_pc  out  XLEN  value pc loads at the next edge; combinational.
REQ-020 flush  out  1  asserted when next_pc is an EXE redirect or a switch_mode redirect; combinational.

Function
REQ-021 BTB entry fields: valid, tag = pc[XLEN-1:IW+2], target[XLEN-1:0], ctr[1:0]. Index = pc[IW+1:2].
REQ-022 hit = valid && tag match at pc's index. pred_taken = hit && ctr[1]. pred_target = entry target on hit, else pc+4.
REQ-023 mispredict is asserted when exe_valid is 1 and either of the following holds:
- exe_is_cf=1 and (exe_taken != exe_pred_taken, or (exe_taken=1 and exe_target != exe_pred_target)).
- exe_is_cf=0 and exe_pred_taken=1 (alias case).
REQ-024 Redirect target: exe_target if exe_is_cf=1 and exe_taken=1, else exe_pc+4.
REQ-025 next_pc priority, highest first:
- switch_mode: pc_csr.
- stall: pc.
- mispredict: redirect target.
- pred_taken: pred_target.
- otherwise: pc+4.
REQ-026 pc <= next_pc every cycle rst=0. All additions are modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-027 BTB update fires when exe_valid=1, stall=0 and switch_mode=0. Update index and tag come from exe_pc.
REQ-028 Update on a control-flow hit:
- exe_taken=1: ctr saturating increment (max 3), target <= exe_target.
- exe_taken=0: ctr saturating decrement (min 0), target unchanged.
REQ-029 Update on a control-flow miss:
- exe_taken=1: allocate (replace) with valid=1, tag, target=exe_target, ctr=2'b10.
- exe_taken=0: no change.
REQ-030 exe_is_cf=0 with a hit at exe_pc: clear that entry's valid. Without a hit: no change.
REQ-031 Same-cycle lookup and update to the same index: the prediction uses pre-update contents; the new contents are visible the next cycle.
REQ-032 At most one BTB entry is written per cycle. No other entry changes.
REQ-033 flush = switch_mode || (!stall && mispredict).

Reset
REQ-034 rst=1 at an edge: pc <= RESET_PC, all valid <= 0, all ctr <= 2'b01. Targets and tags are don't-care.
REQ-035 Reset overrides switch_mode, stall and BTB updates, including mid-operation.
REQ-036 During the reset cycle, outputs are computed from the current register contents. In the first cycle after reset: pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4.

Verification
REQ-037 Sequential fetch: reset with RESET_PC=0x1000, all other inputs 0 -> pc = 0x1000, 0x1004, 0x1008; flush=0.
REQ-038 Allocation then prediction:
- Stimulus: exe_valid=1, exe_is_cf=1, exe_taken=1, exe_pc=0x1008, exe_target=0x2000, exe_pred_taken=0.
- Response: flush=1 and next_pc=0x2000.
- Later, pc=0x1008: pred_taken=1, next_pc=0x2000.
REQ-039 Counter hysteresis on entry 0x1008 (ctr=2):
- One not-taken resolve: ctr=1, pred_taken=0, redirect next_pc=0x100C.
- Three taken resolves: ctr saturates at 3.
REQ-040 Priority:
- switch_mode=1 with pc_csr=0x8000, stall=1 and mispredict all in one cycle -> next_pc=0x8000, flush=1, no BTB write.
- stall=1 with mispredict -> pc held, flush=0.
REQ-041 Alias and conflict:
- Non-cf exe_pc=0x1008 with exe_pred_taken=1 -> entry invalidated, next_pc=0x100C.
- Taken branch at 0x1008+16*4 replaces the 0x1008 entry; a later lookup at 0x1008 misses.
REQ-042 Reset mid-run: rst=1 with mispredict and switch_mode=1 -> next cycle pc=RESET_PC and all lookups miss.
